// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock from a single (WIDTH+1)-bit trial subtraction of the divisor from the
//   shifted partial remainder.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset; takes priority over start
//   start        request pulse; sampled only while idle
//   dividend     unsigned dividend, captured with start
//   divisor      unsigned divisor, captured with start
//   busy         high while an operation is in flight
//   done         one-cycle completion pulse; results are valid from this cycle
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   div_by_zero  set when the last completed operation had divisor == 0
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] r_reg;
   logic [CNT_W-1:0] count;

   logic [WIDTH:0]   t;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;

   // One restoring step. The partial remainder is always below the divisor,
   // so t < 2*divisor and bit WIDTH of diff is exactly the borrow.
   always_comb begin
      t      = {r_reg, q_reg[WIDTH-1]};
      diff   = t - {1'b0, d_reg};
      q_next = {q_reg[WIDTH-2:0], 1'b0};
      r_next = t[WIDTH-1:0];
      if (!diff[WIDTH]) begin
         q_next = {q_reg[WIDTH-2:0], 1'b1};
         r_next = diff[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         q_reg       <= '0;
         d_reg       <= '0;
         r_reg       <= '0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  q_reg <= dividend;
                  d_reg <= divisor;
                  r_reg <= '0;
                  count <= '0;
                  if (divisor == '0) begin
                     // Skip the iterations entirely; report all-ones quotient.
                     state       <= S_DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     busy        <= 1'b1;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end

            S_CALC: begin
               q_reg <= q_next;
               r_reg <= r_next;
               count <= count + 1'b1;
               busy  <= 1'b1;
               if (count == LAST_ITER) begin
                  // Publish the results of the final iteration directly.
                  state       <= S_DONE;
                  quotient    <= q_next;
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed and randomized checks of seq_divider at WIDTH = 16.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W      = 16;
   localparam int WINDOW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int passed = 0;
   int total  = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Launches one operation and watches a fixed window of cycles.
   // Cycle index i = 1 is the cycle right after the start edge.
   // repulse_at / rst_at: cycle index whose following edge samples a second
   // start (50/5) or a reset; 0 disables.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int repulse_at, input int rst_at,
                         output int lat, output int ndone, output int nbusy,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output logic [W-1:0] rq,
                         output logic [W-1:0] rr, output logic rb);
      lat = -1; ndone = 0; nbusy = 0;
      q = '0; r = '0; z = 1'b0; rq = '1; rr = '1; rb = 1'b1;
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      for (int i = 1; i <= WINDOW; i++) begin
         @(negedge clk);
         start    = 1'b0;
         rst      = 1'b0;
         dividend = W'($urandom);
         divisor  = W'($urandom);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = i; q = quotient; r = remainder; z = div_by_zero;
            end
         end
         if (rst_at != 0 && i == rst_at + 1) begin
            rq = quotient; rr = remainder; rb = busy;
         end
         if (i == repulse_at) begin
            start = 1'b1; dividend = 16'd50; divisor = 16'd5;
         end
         if (i == rst_at) rst = 1'b1;
      end
   endtask

   int            lat, ndone, nbusy;
   logic [W-1:0]  q, r, rq, rr;
   logic          z, rb;
   logic [W-1:0]  ra, rbv;

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_quot", 32'(quotient), 0);
      check("reset_rem", 32'(remainder), 0);
      check("reset_dbz", 32'(div_by_zero), 0);
      rst = 1'b0;

      run_op(16'd100, 16'd7, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("100/7_lat", 32'(lat), 17);
      check("100/7_ndone", 32'(ndone), 1);
      check("100/7_busy", 32'(nbusy), 16);
      check("100/7_q", 32'(q), 14);
      check("100/7_r", 32'(r), 2);
      check("100/7_dbz", 32'(z), 0);
      check("100/7_hold_q", 32'(quotient), 14);

      run_op(16'hFFFF, 16'd1, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("ffff/1_q", 32'(q), 32'hFFFF);
      check("ffff/1_r", 32'(r), 0);
      check("ffff/1_lat", 32'(lat), 17);

      run_op(16'hFFFF, 16'hFFFF, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("ffff/ffff_q", 32'(q), 1);
      check("ffff/ffff_r", 32'(r), 0);

      run_op(16'd5, 16'd9, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("5/9_q", 32'(q), 0);
      check("5/9_r", 32'(r), 5);

      run_op(16'd0, 16'd3, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("0/3_q", 32'(q), 0);
      check("0/3_r", 32'(r), 0);
      check("0/3_dbz", 32'(z), 0);

      run_op(16'd1234, 16'd0, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("div0_lat", 32'(lat), 1);
      check("div0_ndone", 32'(ndone), 1);
      check("div0_busy", 32'(nbusy), 1);
      check("div0_q", 32'(q), 32'hFFFF);
      check("div0_r", 32'(r), 1234);
      check("div0_dbz", 32'(z), 1);
      check("div0_hold_dbz", 32'(div_by_zero), 1);

      run_op(16'd40, 16'd6, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("40/6_q", 32'(q), 6);
      check("40/6_r", 32'(r), 4);
      check("40/6_dbz", 32'(z), 0);

      run_op(16'd1000, 16'd3, 5, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("repulse_ndone", 32'(ndone), 1);
      check("repulse_lat", 32'(lat), 17);
      check("repulse_q", 32'(q), 333);
      check("repulse_r", 32'(r), 1);

      run_op(16'd1000, 16'd3, 0, 8, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("abort_ndone", 32'(ndone), 0);
      check("abort_busy", 32'(rb), 0);
      check("abort_q", 32'(rq), 0);
      check("abort_r", 32'(rr), 0);

      run_op(16'd9, 16'd2, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
      check("9/2_q", 32'(q), 4);
      check("9/2_r", 32'(r), 1);
      check("9/2_lat", 32'(lat), 17);

      for (int n = 0; n < 2000; n++) begin
         ra  = W'($urandom);
         rbv = W'($urandom_range(1, 65535));
         run_op(ra, rbv, 0, 0, lat, ndone, nbusy, q, r, z, rq, rr, rb);
         check("rand_lat", 32'(lat), 17);
         check("rand_identity", 32'(q) * 32'(rbv) + 32'(r), 32'(ra));
         check("rand_rem_lt", 32'(r < rbv), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
